// File: rtl/pixel_stream_source.sv
// Raster-order frame reader: registered read strobe, 2-cycle strobe-to-valid_out latency (memory + output register).
// No output backpressure; stall only gates new reads, reads already issued still drain to o_data.
module pixel_stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112,
  parameter int ADDR_WIDTH = 14,
  parameter int ROW_GAP    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH*3-1:0] mem_rdata,
  output logic [DATA_WIDTH*3-1:0] o_data,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, GAP, FLUSH} state_t;

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ADDR_WIDTH-1:0] addr;
  logic [GW-1:0]         gap_cnt;
  logic [1:0]            flush_cnt;
  logic                  rd_q;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      gap_cnt   <= '0;
      flush_cnt <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            gap_cnt <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (!stall) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addr;
            addr      <= addr + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end else begin
                row <= row + 1'b1;
                if (ROW_GAP > 0) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                end
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) state <= READ;
        end
        FLUSH: begin
          // Hold until the final read has passed through the output register.
          if (flush_cnt == 2'd2) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q      <= 1'b0;
      valid_out <= 1'b0;
      o_data    <= '0;
    end else begin
      rd_q      <= mem_rd_en;
      valid_out <= rd_q;
      if (rd_q) o_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Drives two instances (no row gap / 2-cycle row gap) against a cycle-schedule model of the frame scan.
module tb_pixel_stream_source;
  localparam int DW  = 32;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int AW  = 4;
  localparam int N   = W * H;
  localparam int LEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic st [2];
  logic rd [2];
  logic vo [2];
  logic bz [2];
  logic dn [2];
  logic [AW-1:0]   ad   [2];
  logic [3*DW-1:0] od   [2];
  logic [3*DW-1:0] rdat [2];
  logic [3*DW-1:0] mem  [N];

  int vectors = 0;
  int miscompares = 0;
  int cur_t = 0;

  bit              ss    [LEN];
  bit              e_rd  [2][LEN];
  int              e_ad  [2][LEN];
  bit              e_vo  [2][LEN];
  int              e_px  [2][LEN];
  bit              e_bz  [2][LEN];
  bit              e_dn  [2][LEN];
  logic [3*DW-1:0] e_od  [2][LEN];
  logic [3*DW-1:0] last_dat [2];
  int              se [2];

  always #5 clk = ~clk;

  pixel_stream_source #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .ROW_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .stall(stall), .mem_rd_en(rd[0]), .mem_addr(ad[0]),
    .mem_rdata(rdat[0]), .o_data(od[0]), .valid_out(vo[0]), .busy(bz[0]), .done(dn[0]));

  pixel_stream_source #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .ROW_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(st[1]), .stall(stall), .mem_rd_en(rd[1]), .mem_addr(ad[1]),
    .mem_rdata(rdat[1]), .o_data(od[1]), .valid_out(vo[1]), .busy(bz[1]), .done(dn[1]));

  // Synchronous-read frame buffers, one per instance, same contents.
  always @(posedge clk) if (rd[0]) rdat[0] <= mem[ad[0]];
  always @(posedge clk) if (rd[1]) rdat[1] <= mem[ad[1]];

  task automatic chk(input string tag, input int d, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d t=%0d observed=%0h expected=%0h", tag, d, cur_t, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_odata"}, d, od[d], 96'(0));
      chk({tag, "_valid"}, d, 96'(vo[d]), 96'(0));
      chk({tag, "_rden"},  d, 96'(rd[d]), 96'(0));
      chk({tag, "_addr"},  d, 96'(ad[d]), 96'(0));
      chk({tag, "_busy"},  d, 96'(bz[d]), 96'(0));
      chk({tag, "_done"},  d, 96'(dn[d]), 96'(0));
    end
  endtask

  // Expected per-cycle behaviour; cycle t is the clock period after the t-th edge following start.
  task automatic build_model(input bit b2b);
    int g, s, t, p, gap, dt;
    logic [3*DW-1:0] cur;
    for (int d = 0; d < 2; d++) begin
      g = (d == 0) ? 0 : 2;
      for (int u = 0; u < LEN; u++) begin
        e_rd[d][u] = 0; e_ad[d][u] = 0; e_vo[d][u] = 0; e_px[d][u] = 0;
        e_bz[d][u] = 0; e_dn[d][u] = 0;
      end
      se[d] = -1;
      s = 0;
      for (int f = 0; f < (b2b ? 2 : 1); f++) begin
        t = s; p = 0; gap = 0;
        while (p < N) begin
          t++;
          if (gap > 0) gap--;
          else if (!ss[t]) begin
            e_rd[d][t] = 1; e_ad[d][t] = p;
            e_vo[d][t+2] = 1; e_px[d][t+2] = p;
            p++;
            if ((p % W) == 0 && p < N) gap = g;
          end
        end
        dt = t + 3;
        e_dn[d][dt] = 1;
        for (int u = s; u < dt; u++) e_bz[d][u] = 1;
        if (f == 0 && b2b) se[d] = dt + 1;
        s = dt + 1;
      end
      cur = last_dat[d];
      for (int u = 0; u < LEN; u++) begin
        if (e_vo[d][u]) cur = mem[e_px[d][u]];
        e_od[d][u] = cur;
      end
    end
  endtask

  task automatic run_check(input int len, input bit b2b, input int mid_t);
    build_model(b2b);
    st[0] = 1'b1; st[1] = 1'b1;
    for (int t = 0; t <= len; t++) begin
      @(posedge clk); #1;
      cur_t = t;
      for (int d = 0; d < 2; d++) begin
        chk("rd_en", d, 96'(rd[d]), 96'(e_rd[d][t]));
        if (e_rd[d][t]) chk("addr", d, 96'(ad[d]), 96'(e_ad[d][t]));
        chk("valid", d, 96'(vo[d]), 96'(e_vo[d][t]));
        chk("odata", d, od[d], e_od[d][t]);
        chk("busy",  d, 96'(bz[d]), 96'(e_bz[d][t]));
        chk("done",  d, 96'(dn[d]), 96'(e_dn[d][t]));
      end
      stall = ss[t+1];
      for (int d = 0; d < 2; d++) st[d] = ((t + 1) == se[d]) || ((t + 1) == mid_t);
    end
    for (int d = 0; d < 2; d++) last_dat[d] = e_od[d][len];
  endtask

  task automatic clear_stalls();
    for (int u = 0; u < LEN; u++) ss[u] = 0;
  endtask

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    last_dat[0] = '0; last_dat[1] = '0;
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom, $urandom};
    clear_stalls();

    // Reset state.
    #3;
    cur_t = -1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame.
    run_check(20, 1'b0, -1);

    // Three stall cycles after the fifth read.
    ss[6] = 1; ss[7] = 1; ss[8] = 1;
    run_check(24, 1'b0, -1);
    clear_stalls();

    // Random stall pattern over fresh image contents.
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom, $urandom};
    for (int u = 1; u < 42; u++) ss[u] = ($urandom_range(0, 3) == 0);
    run_check(56, 1'b0, -1);
    clear_stalls();

    // Mid-frame start is ignored; start in the done cycle launches the next frame.
    run_check(44, 1'b1, 6);

    // Asynchronous reset right after pixel 6 is read.
    run_check(7, 1'b0, -1);
    #1 rst = 1'b0;
    #1;
    cur_t = -2;
    chk_zero("midrst");
    last_dat[0] = '0; last_dat[1] = '0;
    @(posedge clk); #1;
    chk_zero("rsthold");
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      cur_t = -3 - c;
      for (int d = 0; d < 2; d++) begin
        chk("postrst_valid", d, 96'(vo[d]), 96'(0));
        chk("postrst_busy",  d, 96'(bz[d]), 96'(0));
        chk("postrst_done",  d, 96'(dn[d]), 96'(0));
      end
    end
    run_check(20, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_stream_source.md
# pixel_stream_source

- Frame-buffer reader that drives the pixel stream into the first convolution layer pair.
- On `start`, it scans a WIDTH×HEIGHT image in raster order from a synchronous-read memory holding 3-channel pixels.
- Each read word is presented as `o_data` with `valid_out`, in the exact form the layer chain consumes on `i_data`/`valid_in`.
- Supports a read-gating `stall` input and optional idle cycles between rows. It pulses `done` when the last pixel has left the block.

## Interface
- DATA_WIDTH, 32: bits per channel.
- WIDTH, 112: pixels per row.
- HEIGHT, 112: rows per frame.
- ADDR_WIDTH, 14: memory address width; must satisfy 2^ADDR_WIDTH ≥ WIDTH*HEIGHT.
- ROW_GAP, 0: idle cycles inserted between rows; 0 disables gaps.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame; honoured only in IDLE.
- stall  in  1  while high, no new memory read is issued and scan counters hold.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  linear pixel address, row*WIDTH+col.
- mem_rdata  in  DATA_WIDTH*3  read data, valid exactly 1 cycle after `mem_rd_en`.
- o_data  out  DATA_WIDTH*3  pixel to the layer chain; registered.
- valid_out  out  1  `o_data` holds a pixel this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of frame.

## Operation
- **FSM states:** IDLE, READ, GAP, FLUSH.
- **IDLE:**
  - On `start`=1: clear `col`, `row`, `addr` and `gap_cnt`, then go to READ.
  - Otherwise stay in IDLE.
- **READ, `stall`=0:**
  - Assert `mem_rd_en` with `mem_addr`=`addr`, then increment `addr` by 1; no multiplier is used.
  - `col` increments. When `col`=WIDTH-1: `col`←0 and `row`++.
  - Last pixel of the frame (`row`=HEIGHT-1, `col`=WIDTH-1): go to FLUSH.
  - End of any other row with ROW_GAP>0: go to GAP with `gap_cnt`←0.
- **READ, `stall`=1:**
  - `mem_rd_en`=0; `addr`, `col` and `row` hold.
  - Reads already issued still complete and appear on `o_data`.
  - There is no output backpressure: the downstream layers have no ready signal.
- **GAP:**
  - `mem_rd_en`=0. `gap_cnt` increments every cycle, regardless of `stall`.
  - Return to READ after ROW_GAP cycles.
- **FLUSH:**
  - `mem_rd_en`=0 for 2 cycles, which drains the read/output pipeline.
  - Then go to IDLE and register `done`=1 for one cycle.
- **Output path:** `valid_out` and `o_data` are updated from `mem_rd_en` delayed one cycle and from `mem_rdata`.
  - When the delayed strobe is 1: `o_data`←`mem_rdata` and `valid_out`=1.
  - Otherwise `valid_out`=0 and `o_data` holds its last value.
- **Boundaries:**
  - `start` while `busy`: ignored, no effect on the scan.
  - `start` in the same cycle that `done`=1: accepted, because the state is already IDLE.
  - `stall` during GAP or FLUSH: no effect.
  - `stall` on the last pixel: that read is delayed until `stall` drops.
  - WIDTH=1: every pixel ends a row.
  - HEIGHT=1: no GAP is ever entered.
- **Reset (including mid-frame):**
  - State goes to IDLE; all counters go to 0.
  - In-flight reads are discarded: the delayed strobe is cleared.
  - Outputs: `o_data`=0, `valid_out`=0, `mem_rd_en`=0, `mem_addr`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled high at edge k: first `mem_rd_en` in cycle k+1, first `valid_out` in cycle k+3.
- `mem_rd_en` to `valid_out` latency is 2 cycles: memory 1 plus output register 1.
- Unstalled frame, ROW_GAP=0:
  - Reads occur in cycles k+1..k+N, where N=WIDTH*HEIGHT.
  - `valid_out` is high continuously in cycles k+3..k+N+2.
  - `done`=1 in cycle k+N+3, with `busy`=0 in that same cycle.
- ROW_GAP=G: each of the HEIGHT-1 row boundaries adds G cycles with `valid_out`=0.
- Each stall cycle adds 1 cycle to the frame duration.
- `mem_addr` sequence is strictly 0,1,…,N-1, with no repeats or skips under any `stall` pattern.

## Test plan
- **Basic frame:** WIDTH=4, HEIGHT=3, memory word i = i; pulse `start`.
  - `valid_out` runs 12 consecutive cycles from start+3, carrying `o_data` 0..11.
  - `done` at start+15.
- **Stall:** same frame, `stall` high for 3 cycles after the 5th read.
  - Addresses 0..11 still in order with no duplicates.
  - `valid_out` has a 3-cycle hole after pixel 4.
  - `done` at start+18.
- **Row gaps:** ROW_GAP=2, WIDTH=4, HEIGHT=3.
  - Exactly 2 idle `valid_out` cycles after pixels 3 and 7.
  - No gap after pixel 11; `done` at start+19.
- **Start while busy and back-to-back:** `start` pulsed mid-frame, then again in the `done` cycle.
  - The mid-frame pulse is ignored.
  - The second frame begins reading at address 0 on the next cycle.
- **Reset mid-frame:** drive `rst` low after pixel 6 is read.
  - All outputs go 0 immediately (asynchronously).
  - No further `valid_out` appears.
  - After release, a new `start` reproduces the basic frame exactly.
